// File: rtl/aes_pkg.sv
// Shared AES definitions: byte type, mode encodings and the FIPS-197 S-box tables.
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam logic AES_MODE_ENC = 1'b0;
    localparam logic AES_MODE_DEC = 1'b1;

    localparam int unsigned BEAT_CNT_W = 16;

    localparam byte_t SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sub_bytes_pipe_if.sv
// Stream interface of the byte-substitution unit: input beat side, output beat side, beat counter.
interface aes_sub_bytes_pipe_if #(
    parameter int unsigned LANES = 16
);
    import aes_pkg::*;

    localparam int unsigned DW = 8 * LANES;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic [DW-1:0]         in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_mode;
    logic [DW-1:0]         out_data;
    logic [BEAT_CNT_W-1:0] beat_cnt;

    // Round controller / producer-consumer view
    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_mode, out_data, beat_cnt
    );

    // Substitution unit view
    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_mode, out_data, beat_cnt
    );

endinterface

// File: rtl/aes_sbox_lane.sv
// One byte lane: forward or inverse S-box lookup selected by mode, purely combinational.
module aes_sbox_lane
    import aes_pkg::*;
(
    input  byte_t byte_i,
    input  logic  mode_i,
    output byte_t sub_c_o
);

    // Both tables are read; mode picks which result leaves the lane
    assign sub_c_o = (mode_i == AES_MODE_DEC) ? SBOX_INV[byte_i] : SBOX_FWD[byte_i];

endmodule

// File: rtl/aes_sub_bytes_pipe.sv
// Pipelined AES (Inv)SubBytes over LANES bytes with a single-advance valid/ready chain.
module aes_sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int unsigned LANES        = 16,
    parameter int unsigned PIPE_STAGES  = 2,
    parameter bit          OUT_RST_ZERO = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    aes_sub_bytes_pipe_if.slave bus
);

    localparam int unsigned DW = 8 * LANES;

    logic                  adv_c;
    logic [DW-1:0]         lane_in_c;
    logic [DW-1:0]         lane_out_c;
    logic                  lane_mode_c;
    logic                  lane_valid_c;

    logic                  out_valid_q, out_valid_d;
    logic                  out_mode_q,  out_mode_d;
    logic [DW-1:0]         out_data_q,  out_data_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q,  beat_cnt_d;

    // Whole chain moves together whenever the output slot is empty or being drained
    assign adv_c        = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv_c;

    generate
        if (PIPE_STAGES == 2) begin : g_two_stage
            logic          s1_valid_q;
            logic          s1_mode_q;
            logic [DW-1:0] s1_data_q;

            // Stage-1 control: valid shifts with adv, mode captured only on a transfer
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_valid_q <= 1'b0;
                    s1_mode_q  <= AES_MODE_ENC;
                end else if (adv_c) begin
                    s1_valid_q <= bus.in_valid;
                    if (bus.in_valid) begin
                        s1_mode_q <= bus.in_mode;
                    end
                end
            end

            // Stage-1 payload: no reset needed, qualified by s1_valid_q
            always_ff @(posedge clk) begin
                if (adv_c && bus.in_valid) begin
                    s1_data_q <= bus.in_data;
                end
            end

            assign lane_in_c    = s1_data_q;
            assign lane_mode_c  = s1_mode_q;
            assign lane_valid_c = s1_valid_q;
        end else if (PIPE_STAGES == 1) begin : g_one_stage
            assign lane_in_c    = bus.in_data;
            assign lane_mode_c  = bus.in_mode;
            assign lane_valid_c = bus.in_valid;
        end else begin : g_bad_stages
            $error("aes_sub_bytes_pipe: PIPE_STAGES must be 1 or 2");
        end
    endgenerate

    // Lookup lanes, byte i at [8*i +: 8]
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox_lane u_lane (
            .byte_i  (lane_in_c[8*i +: 8]),
            .mode_i  (lane_mode_c),
            .sub_c_o (lane_out_c[8*i +: 8])
        );
    end

    // Output stage next-state and accepted-beat counter
    always_comb begin
        out_valid_d = out_valid_q;
        out_mode_d  = out_mode_q;
        out_data_d  = out_data_q;
        beat_cnt_d  = beat_cnt_q;
        if (adv_c) begin
            out_valid_d = lane_valid_c;
            if (lane_valid_c) begin
                out_mode_d = lane_mode_c;
                out_data_d = lane_out_c;
            end
        end
        if (out_valid_q && bus.out_ready) begin
            beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
        end
    end

    // Output control registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_mode_q  <= AES_MODE_ENC;
            beat_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_mode_q  <= out_mode_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    // Output payload; the reset clear can be dropped to save reset routing on a wide bus
    always_ff @(posedge clk) begin
        if (!rst_n && OUT_RST_ZERO) begin
            out_data_q <= '0;
        end else begin
            out_data_q <= out_data_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_mode  = out_mode_q;
    assign bus.out_data  = out_data_q;
    assign bus.beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
// Scoreboard bench for aes_sub_bytes_pipe against a GF(2^8) arithmetic S-box model.
module tb_aes_sub_bytes_pipe;

    localparam int unsigned LANES       = 16;
    localparam int unsigned PIPE_STAGES = 2;
    localparam int unsigned DW          = 8 * LANES;

    typedef struct {
        logic          mode;
        logic [DW-1:0] data;
        int            issue;
        bit            chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_sub_bytes_pipe_if #(.LANES(LANES)) bus ();

    aes_sub_bytes_pipe #(
        .LANES        (LANES),
        .PIPE_STAGES  (PIPE_STAGES),
        .OUT_RST_ZERO (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_vec      = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   n_out_xfer = 0;
    exp_t sb[$];
    logic [7:0] fwd_ref [256];
    logic [7:0] inv_ref [256];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model: S-box from field arithmetic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox_math(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        if (x == 8'h00) r = 8'h00;
        else for (int k = 0; k < 254; k++) r = gmul(r, x);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [DW-1:0] model(input logic mode, input logic [DW-1:0] d);
        logic [DW-1:0] e;
        for (int i = 0; i < LANES; i++)
            e[8*i +: 8] = mode ? inv_ref[d[8*i +: 8]] : fwd_ref[d[8*i +: 8]];
        return e;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < LANES; i++) d[8*i +: 8] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event, expected normal completion (t=%0t)", name, $time);
    endtask

    // ---------------- monitor: pops expected beats on every output transfer ----------------
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_mode;
    exp_t          mon_e;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("in_ready_rule", DW'(bus.in_ready), DW'(!bus.out_valid || bus.out_ready));
            if (prev_stall) begin
                chk("stall_valid", DW'(bus.out_valid), DW'(1'b1));
                chk("stall_data", bus.out_data, prev_data);
                chk("stall_mode", DW'(bus.out_mode), DW'(prev_mode));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_data", bus.out_data, mon_e.data);
                    chk("out_mode", DW'(bus.out_mode), DW'(mon_e.mode));
                    if (mon_e.chk_lat) chk("latency", DW'(cyc - mon_e.issue), DW'(PIPE_STAGES));
                    n_out_xfer++;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_mode  = bus.out_mode;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- driver tasks (entered and left at posedge + 1) ----------------
    task automatic send(input logic mode, input logic [DW-1:0] data,
                        input logic [DW-1:0] req, input bit lat);
        exp_t e;
        bit   done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_data  = data;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.mode = mode; e.data = req; e.issue = cyc; e.chk_lat = lat;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) fail_now("send_timeout");
        bus.in_valid = 1'b0;
        bus.in_data  = 'x;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) fail_now({tag, "_drain_timeout"});
        @(negedge clk);
        chk({tag, "_beat_cnt"}, DW'(bus.beat_cnt), DW'(16'(n_out_xfer)));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        n_out_xfer   = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] d, f;
        bit            rnd_done;

        for (int x = 0; x < 256; x++) fwd_ref[x] = sbox_math(8'(x));
        for (int x = 0; x < 256; x++) inv_ref[fwd_ref[x]] = 8'(x);

        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);

        // reset state
        @(negedge clk);
        chk("rst_out_valid", DW'(bus.out_valid), '0);
        chk("rst_out_mode", DW'(bus.out_mode), '0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_beat_cnt", DW'(bus.beat_cnt), '0);
        chk("rst_in_ready", DW'(bus.in_ready), DW'(1'b1));
        @(posedge clk); #1 rst_n = 1'b1;

        // FIPS-197 round-1 SubBytes vector
        send(1'b0, 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19,
                   128'h3052411e_e55db4b8_f198bfe0_ae1127d4, 1'b1);
        // inverse known points: 63->00, 00->52, ff->7d, ed->53, remaining lanes 00->52
        send(1'b1, {96'h0, 32'hedff0063}, {{12{8'h52}}, 32'h537d5200}, 1'b1);
        drain("known");

        // alternating modes at full rate
        for (int i = 0; i < 24; i++) begin
            d = rand_data();
            send(1'(i & 1), d, model(1'(i & 1), d), 1'b1);
        end
        drain("alt");

        // backpressure: out_ready low for 3 cycles mid-stream
        fork
            for (int i = 0; i < 8; i++) begin
                d = rand_data();
                send(1'(i % 3 == 0), d, model(1'(i % 3 == 0), d), 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain("bp");

        // random traffic with random gaps and random backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    logic m;
                    m = 1'($urandom_range(0, 1));
                    d = rand_data();
                    send(m, d, model(m, d), 1'b0);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                rnd_done = 1'b1;
            end
            while (!rnd_done) begin
                @(posedge clk); #1;
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        bus.out_ready = 1'b1;
        drain("rand");

        // reset with two beats in flight
        for (int i = 0; i < 2; i++) begin
            d = rand_data();
            send(1'b0, d, model(1'b0, d), 1'b1);
        end
        rst_n = 1'b0;
        sb.delete();
        n_out_xfer = 0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", DW'(bus.out_valid), '0);
        chk("midrst_beat_cnt", DW'(bus.beat_cnt), '0);
        chk("midrst_in_ready", DW'(bus.in_ready), DW'(1'b1));
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        d = rand_data();
        send(1'b1, d, model(1'b1, d), 1'b1);
        drain("post_rst");

        // round trip over every byte value, 512 beats from a clean reset
        do_reset();
        for (int x = 0; x < 256; x++) begin
            for (int i = 0; i < LANES; i++) d[8*i +: 8] = 8'(x + 37 * i);
            send(1'b0, d, model(1'b0, d), 1'b1);
        end
        for (int x = 0; x < 256; x++) begin
            for (int i = 0; i < LANES; i++) d[8*i +: 8] = 8'(x + 37 * i);
            f = model(1'b0, d);
            send(1'b1, f, d, 1'b1);
        end
        drain("roundtrip");
        @(negedge clk);
        chk("beat_cnt_512", DW'(bus.beat_cnt), DW'(16'd512));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
